fp_div_result_sink: RTL and testbench

//  Consumer end of the FP divider result stream: AXI-Stream-style slave that accepts

---
 rtl/fp_div_result_sink.sv | 138 +++++++++++++
 tb/tb_fp_div_result_sink.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_result_sink.sv
// Result sink for the FP divider stream: collects DEPTH binary32 quotients into a readable
// buffer and checks each one against the parent-supplied expected value within ULP_TOL.
module fp_div_result_sink #(
    parameter  int DEPTH   = 8,
    parameter  int ULP_TOL = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   s_res_tdata,
    input  logic          s_res_tvalid,
    output logic          s_res_tready,
    output logic [AW-1:0] exp_idx,
    input  logic [31:0]   exp_data,
    input  logic          clear,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] last_err_idx
);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW:0]   wr_ptr;
    logic          ready_en;
    logic [31:0]   mem [DEPTH];

    logic          xfer;
    logic          last_xfer;

    logic          cmp_valid;
    logic [31:0]   cmp_res;
    logic [31:0]   cmp_exp;
    logic [AW-1:0] cmp_idx;

    logic          res_nan;
    logic          exp_nan;
    logic [30:0]   mag_diff;
    logic          cmp_match;

    // Ready is held low for the first cycle out of reset and whenever a clear is pending.
    assign s_res_tready = ready_en && (state_q == S_COLLECT) && !clear;
    assign xfer         = s_res_tvalid && s_res_tready;
    assign last_xfer    = xfer && (wr_ptr == (AW+1)'(DEPTH - 1));
    assign exp_idx      = wr_ptr[AW-1:0];
    assign done         = (state_q == S_DONE);
    assign pass         = done && (err_count == '0);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_COLLECT;
        end else begin
            case (state_q)
                S_COLLECT: if (last_xfer)  state_d = S_FLUSH;
                S_FLUSH:   if (!cmp_valid) state_d = S_DONE;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_COLLECT;
            endcase
        end
    end

    // NaN expectation accepts any NaN; signed zeros are equal; otherwise distance in ULPs.
    always_comb begin
        res_nan   = (cmp_res[30:23] == 8'hFF) && (cmp_res[22:0] != 23'd0);
        exp_nan   = (cmp_exp[30:23] == 8'hFF) && (cmp_exp[22:0] != 23'd0);
        mag_diff  = (cmp_res[30:0] >= cmp_exp[30:0]) ? (cmp_res[30:0] - cmp_exp[30:0])
                                                     : (cmp_exp[30:0] - cmp_res[30:0]);
        cmp_match = 1'b0;
        if (exp_nan) begin
            cmp_match = res_nan;
        end else if ((cmp_res[30:0] == 31'd0) && (cmp_exp[30:0] == 31'd0)) begin
            cmp_match = 1'b1;
        end else if (cmp_res[31] != cmp_exp[31]) begin
            cmp_match = 1'b0;
        end else begin
            cmp_match = (mag_diff <= 31'(ULP_TOL));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            wr_ptr       <= '0;
            ready_en     <= 1'b0;
            cmp_valid    <= 1'b0;
            err_count    <= '0;
            last_err_idx <= '0;
        end else begin
            state_q  <= state_d;
            ready_en <= 1'b1;
            if (clear) begin
                wr_ptr       <= '0;
                cmp_valid    <= 1'b0;
                err_count    <= '0;
                last_err_idx <= '0;
            end else begin
                cmp_valid <= xfer;
                if (xfer) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (cmp_valid && !cmp_match) begin
                    if (err_count != (AW+1)'(DEPTH)) begin
                        err_count <= err_count + 1'b1;
                    end
                    last_err_idx <= cmp_idx;
                end
            end
        end
    end

    // Buffer and compare operands are plain datapath; cmp_valid qualifies the latter.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wr_ptr[AW-1:0]] <= s_res_tdata;
            cmp_res             <= s_res_tdata;
            cmp_exp             <= exp_data;
            cmp_idx             <= wr_ptr[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_fp_div_result_sink.sv
// Scoreboard bench for fp_div_result_sink: stimulus queues expected transfers, run
// outcomes and readback words; negedge monitors pop and compare as the DUT presents them.
module tb_fp_div_result_sink;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   s_res_tdata;
    logic          s_res_tvalid;
    logic          s_res_tready;
    logic [AW-1:0] exp_idx;
    logic [31:0]   exp_data;
    logic          clear;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] last_err_idx;

    logic [31:0] res_tbl [DEPTH];
    logic [31:0] exp_tbl [DEPTH];
    int          gap_tbl [DEPTH];

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   data;
        logic          last;
    } xfer_t;

    typedef struct packed {
        logic [AW:0]   err;
        logic          pass;
        logic [AW-1:0] last;
    } outcome_t;

    xfer_t       xfer_q[$];
    outcome_t    res_q[$];
    logic [31:0] rd_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;
    logic done_prev = 1'b0;
    logic rd_en_tb = 1'b0;
    logic rd_pend = 1'b0;

    assign exp_data = exp_tbl[exp_idx];

    fp_div_result_sink #(.DEPTH(DEPTH), .ULP_TOL(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_res_tdata  (s_res_tdata),
        .s_res_tvalid (s_res_tvalid),
        .s_res_tready (s_res_tready),
        .exp_idx      (exp_idx),
        .exp_data     (exp_data),
        .clear        (clear),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .last_err_idx (last_err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_en_tb;
    end

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endfunction

    // Transfer and run-outcome monitor.
    always @(negedge clk) begin
        xfer_t    xe;
        outcome_t oe;
        if (s_res_tvalid && s_res_tready) begin
            if (xfer_q.size() == 0) begin
                checkOutput("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                xe = xfer_q.pop_front();
                checkOutput("xfer_idx", 32'(exp_idx), 32'(xe.idx));
                checkOutput("xfer_data", s_res_tdata, xe.data);
                if (xe.last) last_edge = cyc + 1;
            end
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                oe = res_q.pop_front();
                checkOutput("err_count", 32'(err_count), 32'(oe.err));
                checkOutput("pass", 32'(pass), 32'(oe.pass));
                checkOutput("last_err_idx", 32'(last_err_idx), 32'(oe.last));
                checkOutput("done_latency", 32'(cyc - last_edge), 32'd2);
            end
        end
        done_prev <= done;
    end

    // Readback monitor: rd_data is due one clock after rd_addr.
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) checkOutput("rd_underflow", 32'd1, 32'd0);
            else checkOutput("rd_data", rd_data, rd_q.pop_front());
        end
    end

    task automatic send_word(input logic [31:0] d);
        int budget = 0;
        s_res_tdata  = d;
        s_res_tvalid = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (!s_res_tready && budget < 40);
        if (!s_res_tready) checkOutput("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int n, input bit push_result, input logic [AW:0] e_err,
                                 input logic e_pass, input logic [AW-1:0] e_last,
                                 input bit hold_after);
        outcome_t oe;
        @(posedge clk);
        #1;
        if (push_result) begin
            oe.err  = e_err;
            oe.pass = e_pass;
            oe.last = e_last;
            res_q.push_back(oe);
        end
        for (int i = 0; i < n; i++) begin
            xfer_t xe;
            s_res_tvalid = 1'b0;
            repeat (gap_tbl[i]) begin
                @(posedge clk);
                #1;
            end
            xe.idx  = AW'(i);
            xe.data = res_tbl[i];
            xe.last = (i == DEPTH - 1);
            xfer_q.push_back(xe);
            send_word(res_tbl[i]);
        end
        if (hold_after) begin
            s_res_tvalid = 1'b1;
            s_res_tdata  = 32'hDEADBEEF;
        end else begin
            s_res_tvalid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
    endtask

    task automatic read_back();
        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk);
            #1;
            rd_addr  = AW'(a);
            rd_en_tb = 1'b1;
            rd_q.push_back(res_tbl[a]);
        end
        @(posedge clk);
        #1;
        rd_en_tb = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        clear        = 1'b1;
        s_res_tvalid = 1'b1;
        s_res_tdata  = 32'hCAFEF00D;
        @(negedge clk);
        checkOutput("clear_tready", 32'(s_res_tready), 32'd0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        s_res_tvalid = 1'b0;
        checkOutput("clear_done", 32'(done), 32'd0);
        checkOutput("clear_err", 32'(err_count), 32'd0);
        checkOutput("clear_idx", 32'(exp_idx), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        clear        = 1'b0;
        s_res_tvalid = 1'b0;
        s_res_tdata  = '0;
        rd_addr      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_tbl[i] = '0;
            res_tbl[i] = '0;
            gap_tbl[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err", 32'(err_count), 32'd0);
        checkOutput("rst_last", 32'(last_err_idx), 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);
        checkOutput("rst_tready", 32'(s_res_tready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_cycle_tready", 32'(s_res_tready), 32'd0);
        @(negedge clk);
        checkOutput("second_cycle_tready", 32'(s_res_tready), 32'd1);

        // Exact quotients, back to back, then hold tvalid with a ninth word.
        res_tbl = '{32'h40400000, 32'h3F800000, 32'h3F000000, 32'hC0000000,
                    32'h3EAAAAAB, 32'h41200000, 32'h7F800000, 32'h00000001};
        exp_tbl = res_tbl;
        applyStimulus(DEPTH, 1'b1, 4'd0, 1'b1, 3'd0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("hold_tready", 32'(s_res_tready), 32'd0);
        end
        checkOutput("hold_exp_idx", 32'(exp_idx), 32'd0);
        wait_done();
        @(posedge clk);
        #1;
        s_res_tvalid = 1'b0;
        read_back();
        pulse_clear();

        // ULP tolerance, signed zero, NaN and sign rules, with tvalid gaps.
        res_tbl = '{32'h40400001, 32'h40400002, 32'h3F7FFFFF, 32'h7F800000,
                    32'h80000000, 32'h7FC00001, 32'h3F800000, 32'hBF800000};
        exp_tbl = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h7F7FFFFF,
                    32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h3F800000};
        gap_tbl = '{0, 2, 1, 0, 3, 0, 1, 2};
        applyStimulus(DEPTH, 1'b1, 4'd3, 1'b0, 3'd7, 1'b0);
        wait_done();
        read_back();
        pulse_clear();

        // Partial run aborted by reset after four transfers.
        res_tbl = '{32'h40400000, 32'h40400002, 32'h3F800000, 32'h3F800000,
                    32'h0, 32'h0, 32'h0, 32'h0};
        exp_tbl = '{32'h40400000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                    32'h0, 32'h0, 32'h0, 32'h0};
        gap_tbl = '{0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(4, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("abort_err", 32'(err_count), 32'd1);
        checkOutput("abort_last", 32'(last_err_idx), 32'd1);
        checkOutput("abort_exp_idx", 32'(exp_idx), 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("midrst_err", 32'(err_count), 32'd0);
        checkOutput("midrst_last", 32'(last_err_idx), 32'd0);
        checkOutput("midrst_exp_idx", 32'(exp_idx), 32'd0);
        checkOutput("midrst_tready", 32'(s_res_tready), 32'd0);
        checkOutput("midrst_rd_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fresh run after reset: NaN sign, Inf vs NaN, tiny sign flip, NaN expectation.
        res_tbl = '{32'hFFC00000, 32'h7FC00000, 32'h00000001, 32'h00000000,
                    32'h80000001, 32'h3F800000, 32'h40000000, 32'h42280000};
        exp_tbl = '{32'h7FC00000, 32'h7F800000, 32'h80000001, 32'h80000000,
                    32'h80000000, 32'h3F800000, 32'h7F800001, 32'h42280001};
        gap_tbl = '{1, 0, 0, 2, 0, 0, 1, 0};
        applyStimulus(DEPTH, 1'b1, 4'd3, 1'b0, 3'd6, 1'b0);
        wait_done();
        read_back();
        pulse_clear();

        // Every result mismatches: error count reaches DEPTH.
        for (int i = 0; i < DEPTH; i++) begin
            res_tbl[i] = 32'h3F800000 + 32'(i);
            exp_tbl[i] = 32'hBF800000 + 32'(i);
            gap_tbl[i] = 0;
        end
        applyStimulus(DEPTH, 1'b1, 4'd8, 1'b0, 3'd7, 1'b0);
        wait_done();
        read_back();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("xfer_q_left", 32'(xfer_q.size()), 32'd0);
        checkOutput("res_q_left", 32'(res_q.size()), 32'd0);
        checkOutput("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
